// File: rtl/io_switch_reader.sv
// IO-page input responder: synchronized, debounced switches/keys with sticky W1C change/press flags.
// Read data is combinational; irq is registered one cycle behind the flag registers.
module io_switch_reader #(
   parameter int N_SW            = 18,
   parameter int N_KEY           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [N_SW-1:0]   SW,
   input  logic [N_KEY-1:0]  KEY,
   input  logic              io_sel,
   input  logic [29:0]       mem_wordaddr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wmask,
   input  logic              mem_rstrb,
   output logic [31:0]       io_rdata,
   output logic              irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [CW-1:0]    tick_cnt;
   logic             tick;

   logic [N_SW-1:0]  sw_s1, sw_s2, sw_h0, sw_h1;
   logic [N_SW-1:0]  sws, sws_nxt, sw_chg, sw_chg_set, sw_chg_clr;

   // Key history and level are kept in the pressed-is-1 domain.
   logic [N_KEY-1:0] key_s1, key_s2, key_act, key_h0, key_h1;
   logic [N_KEY-1:0] keys, keys_nxt, key_press, key_press_set, key_press_clr;

   logic             wr;
   logic             unused_ok;

   assign tick = (tick_cnt == CW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         key_s1 <= '1;
         key_s2 <= '1;
      end else begin
         sw_s1  <= SW;
         sw_s2  <= sw_s1;
         key_s1 <= KEY;
         key_s2 <= key_s1;
      end
   end

   assign key_act = ~key_s2;

   // The three samples judged on a tick are the incoming one plus the two stored.
   always_comb begin
      sws_nxt  = sws;
      keys_nxt = keys;
      if (tick) begin
         sws_nxt  = (sw_s2 & sw_h0 & sw_h1) | (sws & (sw_s2 | sw_h0 | sw_h1));
         keys_nxt = (key_act & key_h0 & key_h1) | (keys & (key_act | key_h0 | key_h1));
      end
   end

   assign sw_chg_set    = sws_nxt ^ sws;
   assign key_press_set = keys_nxt & ~keys;

   assign wr            = io_sel & (|mem_wmask);
   assign sw_chg_clr    = (wr & mem_wordaddr[3]) ? mem_wdata[N_SW-1:0]  : '0;
   assign key_press_clr = (wr & mem_wordaddr[5]) ? mem_wdata[N_KEY-1:0] : '0;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sw_h0     <= '0;
         sw_h1     <= '0;
         key_h0    <= '0;
         key_h1    <= '0;
         sws       <= '0;
         keys      <= '0;
         sw_chg    <= '0;
         key_press <= '0;
         irq       <= 1'b0;
      end else begin
         if (tick) begin
            sw_h0  <= sw_s2;
            sw_h1  <= sw_h0;
            key_h0 <= key_act;
            key_h1 <= key_h0;
         end
         sws       <= sws_nxt;
         keys      <= keys_nxt;
         // Set dominates a coincident clear.
         sw_chg    <= (sw_chg & ~sw_chg_clr) | sw_chg_set;
         key_press <= (key_press & ~key_press_clr) | key_press_set;
         irq       <= (|sw_chg) | (|key_press);
      end
   end

   always_comb begin
      io_rdata = '0;
      if (io_sel) begin
         if (mem_wordaddr[2]) io_rdata = io_rdata | 32'(sws);
         if (mem_wordaddr[3]) io_rdata = io_rdata | 32'(sw_chg);
         if (mem_wordaddr[4]) io_rdata = io_rdata | 32'(keys);
         if (mem_wordaddr[5]) io_rdata = io_rdata | 32'(key_press);
      end
   end

   assign unused_ok = ^{mem_rstrb, mem_wordaddr[29:6], mem_wordaddr[1:0], mem_wdata[31:N_SW]};

endmodule

// File: tb/tb_io_switch_reader.sv
// Directed bench for io_switch_reader with DEBOUNCE_CYCLES=4 and a queue of expected reads.
module tb_io_switch_reader;

   localparam int N_SW  = 18;
   localparam int N_KEY = 4;
   localparam int DC    = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic [N_SW-1:0]   sw;
   logic [N_KEY-1:0]  key;
   logic              io_sel;
   logic [29:0]       wordaddr;
   logic [31:0]       wdata;
   logic [3:0]        wmask;
   logic              rstrb;
   logic [31:0]       rdata;
   logic              irq;

   typedef struct {
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   io_switch_reader #(.N_SW(N_SW), .N_KEY(N_KEY), .DEBOUNCE_CYCLES(DC)) dut (
      .CLOCK_50     (clk),
      .resetn       (resetn),
      .SW           (sw),
      .KEY          (key),
      .io_sel       (io_sel),
      .mem_wordaddr (wordaddr),
      .mem_wdata    (wdata),
      .mem_wmask    (wmask),
      .mem_rstrb    (rstrb),
      .io_rdata     (rdata),
      .irq          (irq)
   );

   always #10 clk = ~clk;

   // Edges since reset release; debounce ticks take effect on edges that are multiples of DC.
   always @(posedge clk) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   function automatic string tag(input int s);
      case (s)
         0:       return "irq";
         2:       return "SWS";
         3:       return "SW_CHG";
         4:       return "KEYS";
         5:       return "KEY_PRESS";
         6:       return "rd_io_sel0";
         7:       return "rd_addr0";
         8:       return "rd_SWS|SW_CHG";
         default: return "unknown";
      endcase
   endfunction

   task automatic push(input int s, input logic [31:0] v);
      exp_t e;
      e.sel = s;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         io_sel   = 1'b1;
         wordaddr = '0;
         case (e.sel)
            6:       begin io_sel = 1'b0; wordaddr = 30'h4; end
            7:       wordaddr = '0;
            8:       wordaddr = 30'hC;
            2, 3, 4, 5: wordaddr = 30'(1) << e.sel;
            default: wordaddr = '0;
         endcase
         #1;
         obs = (e.sel == 0) ? {31'b0, irq} : rdata;
         n_tests++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s got %h expected %h", tag(e.sel), obs, e.val);
         end
      end
      io_sel   = 1'b0;
      wordaddr = '0;
   endtask

   task automatic write(input int bitn, input logic [31:0] d);
      io_sel   = 1'b1;
      wordaddr = 30'(1) << bitn;
      wdata    = d;
      wmask    = 4'hF;
      @(negedge clk);
      io_sel   = 1'b0;
      wordaddr = '0;
      wdata    = '0;
      wmask    = '0;
   endtask

   task automatic push_all_zero();
      push(2, 0); push(3, 0); push(4, 0); push(5, 0); push(0, 0);
   endtask

   initial begin
      int t1, t3, guard;
      resetn = 1'b0; sw = '0; key = 4'hF; io_sel = 1'b0;
      wordaddr = '0; wdata = '0; wmask = '0; rstrb = 1'b0;

      repeat (2) @(negedge clk);
      push_all_zero(); drain();
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      push_all_zero(); drain();

      // Switch pattern settles within 2 + 3*DC + 1 clocks.
      sw = 18'h2A5A5;
      repeat (16) @(negedge clk);
      push(2, 32'h2A5A5); push(3, 32'h2A5A5); push(0, 1); drain();

      write(3, 32'h0000F);
      push(3, 32'h2A5A0); push(0, 1); drain();
      write(3, 32'h3FFFF);
      push(3, 0); push(2, 32'h2A5A5); drain();
      @(negedge clk);
      push(0, 0); drain();

      // Short key glitch must be filtered.
      key = 4'b1011;
      repeat (5) @(negedge clk);
      key = 4'hF;
      repeat (16) @(negedge clk);
      push(4, 0); push(5, 0); push(0, 0); drain();

      key = 4'b1011;
      repeat (20) @(negedge clk);
      push(4, 32'h4); push(5, 32'h4); drain();
      key = 4'hF;
      repeat (16) @(negedge clk);
      push(4, 0); push(5, 32'h4); push(0, 1); drain();

      write(5, 32'h4);
      push(5, 0); drain();
      @(negedge clk);
      push(0, 0); drain();

      // Clear lands on the exact edge the new press is debounced.
      key = 4'b1011;
      t1 = ((cyc + 3 + DC - 1) / DC) * DC;
      t3 = t1 + 2 * DC;
      guard = 0;
      while (cyc != t3 - 1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      write(5, 32'h4);
      push(5, 32'h4); push(4, 32'h4); drain();
      @(negedge clk);
      push(0, 1); drain();

      // Reset in the middle of a switch debounce.
      sw = 18'h15A5A;
      repeat (6) @(negedge clk);
      resetn = 1'b0;
      #1;
      push_all_zero(); drain();
      @(negedge clk);
      resetn = 1'b1;
      repeat (11) @(negedge clk);
      push(2, 0); push(3, 0); drain();
      @(negedge clk);
      push(2, 32'h15A5A); push(3, 32'h15A5A); drain();
      push(6, 0); push(7, 0); push(8, 32'h15A5A); drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/io_switch_reader.md
# io_switch_reader

Memory-mapped input responder for the processor's IO page: synchronizes and debounces the 18 slide switches and 4 push-buttons, and keeps sticky change/press flags. The processor reads these registers and clears the flags with write-1-to-clear stores. It shares the one-hot word-address decode used by the LED and 7-segment writers. Read data is returned combinationally, so it drops straight into the top-level `mem_rdata` mux.

## Interface
- `N_SW`, default 18: number of slide switches.
- `N_KEY`, default 4: number of push-buttons (raw inputs active-low).
- `DEBOUNCE_CYCLES`, default 50000: sample period in clocks (1 ms at 50 MHz); must be ≥ 2.
- `CLOCK_50`  in  1  system clock; all state on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `SW`  in  N_SW  raw slide switches, asynchronous.
- `KEY`  in  N_KEY  raw push-buttons, asynchronous, 0 = pressed.
- `io_sel`  in  1  access targets the IO page (`isIO`).
- `mem_wordaddr`  in  30  word address; one-hot register select.
- `mem_wdata`  in  32  store data.
- `mem_wmask`  in  4  byte strobes; any bit set = write.
- `mem_rstrb`  in  1  read strobe; informational only, reads have no side effects.
- `io_rdata`  out  32  read data, combinational.
- `irq`  out  1  OR of all sticky flags, registered.

## Operation
- Register select uses one-hot `mem_wordaddr` bits:
  - bit 2 `SWS` (R): debounced switch levels in [N_SW-1:0].
  - bit 3 `SW_CHG` (R/W1C): sticky per-switch change flags.
  - bit 4 `KEYS` (R): debounced key state in [N_KEY-1:0], 1 = pressed.
  - bit 5 `KEY_PRESS` (R/W1C): sticky per-key press flags.
- `io_rdata` is zero-extended. It returns 0 when `io_sel`=0 or no select bit is set. If several select bits are set, it is the OR of the selected registers.
- Synchronizer: 2 flops per input. SW flops reset to 0; KEY flops reset to 1 (released).
- Prescaler `tick_cnt`, width $clog2(DEBOUNCE_CYCLES):
  - counts 0..DEBOUNCE_CYCLES-1 and wraps to 0;
  - `tick` is asserted for exactly one cycle when the count equals DEBOUNCE_CYCLES-1.
- Debounce, per bit, on `tick` only:
  - shift the synchronized value into a 3-sample history;
  - when all 3 samples agree and differ from the current debounced level, the level updates;
  - otherwise the level holds.
  - History resets to the inactive value (SW 0, KEY 1).
- Flags:
  - a debounced SW bit that changes either way sets its `SW_CHG` bit;
  - a debounced KEY going released→pressed sets its `KEY_PRESS` bit; release sets nothing.
- W1C: when `io_sel` & |`mem_wmask` & select bit 3 (or bit 5), flag bits with `mem_wdata` = 1 clear and bits with 0 are untouched.
  - Writes to `SWS`/`KEYS` are ignored.
  - Byte lanes are not honoured; any strobe is a full-word write.
- Simultaneous set and clear of the same flag in one cycle: set wins, and the flag stays 1.
- `irq` <= |SW_CHG | |KEY_PRESS, one cycle after the flag register updates.

## Timing
- Reset (async assert, sync-release behaviour is the top's concern): `tick_cnt`, SWS, SW_CHG, KEYS, KEY_PRESS and `irq` are all 0. `io_rdata` therefore reads 0 for every register.
- Switches already high at reset are reported as a change: SWS and SW_CHG bits set after the third tick.
- Input-to-SWS latency: 2 sync cycles plus 3 ticks. Worst case is 2 + 3·DEBOUNCE_CYCLES + 1 clocks after a clean edge.
- Glitches shorter than one tick period never reach the debounced level when they cover at most 2 consecutive samples.
- Flag update: same edge as the debounced level change. `irq` follows one cycle later.
- W1C takes effect on the write edge; a read in the next cycle sees the cleared value.
- Read path: `io_rdata` reflects register state in the same cycle that the address is presented.
- Reset mid-debounce discards the history and the prescaler phase; the next tick comes DEBOUNCE_CYCLES clocks after release.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then read SWS, SW_CHG, KEYS and KEY_PRESS with SW=0 and KEY=4'hF → all 0 and `irq`=0.
- Set SW=18'h2A5A5 and hold → within 2+12+1 clocks SWS=0x2A5A5 and SW_CHG=0x2A5A5; `irq`=1 one cycle later.
- Write 0x0000F to SW_CHG → SW_CHG=0x2A5A0 and `irq` stays 1. Write 0x3FFFF → SW_CHG=0, then `irq`=0.
- Pulse KEY[2] low for 5 clocks (spanning ≤ 2 ticks) → KEYS and KEY_PRESS stay 0. Hold KEY[2] low for 20 clocks → KEYS=4'b0100 and KEY_PRESS=4'b0100. Release → KEYS=0 while KEY_PRESS stays 4'b0100.
- Issue the W1C of KEY_PRESS bit 2 on the same cycle as a new press of KEY[2] is debounced → KEY_PRESS bit 2 reads 1.
- Assert `resetn`=0 mid-debounce while SW toggles → all outputs 0 immediately. Read with `io_sel`=0 or `mem_wordaddr`=0 → `io_rdata`=0.
